// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the 8-digit combination lock: FSM state encodings,
// digit geometry, button priority ordering and BCD helper functions. Also used
// by the display decoder, so the state encodings are part of the external
// contract and must not be renumbered.
// -----------------------------------------------------------------------------
package lock_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int PTR_W      = $clog2(NUM_DIGITS);
  localparam int CODE_W     = NUM_DIGITS * DIGIT_W;

  // Encodings 6 and 7 are unused; the FSM recovers from them to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_OPEN     = 3'd3,
    ST_SET_CODE = 3'd4,
    ST_LOCKOUT  = 3'd5
  } state_e;

  // Winning button after priority resolution. Numeric order follows priority:
  // a larger value beats a smaller one.
  typedef enum logic [2:0] {
    BTN_NONE  = 3'd0,
    BTN_INC   = 3'd1,
    BTN_NEXT  = 3'd2,
    BTN_SET   = 3'd3,
    BTN_ENTER = 3'd4
  } btn_e;

  // Only the highest-priority pulse of a cycle acts; the others are dropped.
  function automatic btn_e pick_btn(input logic inc, input logic next,
                                    input logic enter, input logic set);
    btn_e b;
    if (enter)     b = BTN_ENTER;
    else if (set)  b = BTN_SET;
    else if (next) b = BTN_NEXT;
    else if (inc)  b = BTN_INC;
    else           b = BTN_NONE;
    return b;
  endfunction

  // Decimal increment of one BCD digit: 9 wraps to 0.
  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
    return (d == DIGIT_W'(9)) ? '0 : d + DIGIT_W'(1);
  endfunction

endpackage

// File: rtl/digit_entry_bank.sv
// -----------------------------------------------------------------------------
// digit_entry_bank
// Holds the digits being typed (or programmed) and the edit pointer.
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   inc_i     in   increment (mod 10) the digit under the pointer
//   next_i    in   advance the pointer (mod NUM_DIGITS)
//   clear_i   in   zero all digits and the pointer; wins over inc_i/next_i
//   ptr_o     out  current pointer
//   digits_o  out  packed BCD digits, digit i in [4i+3:4i]
// The sequencer guarantees at most one of inc_i/next_i per cycle.
// -----------------------------------------------------------------------------
module digit_entry_bank #(
  parameter int NUM_DIGITS = lock_pkg::NUM_DIGITS,
  localparam int PTR_W     = $clog2(NUM_DIGITS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   inc_i,
  input  logic                                   next_i,
  input  logic                                   clear_i,
  output logic [PTR_W-1:0]                       ptr_o,
  output logic [NUM_DIGITS*lock_pkg::DIGIT_W-1:0] digits_o
);

  import lock_pkg::*;

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_q, digits_d;
  logic [PTR_W-1:0]                   ptr_q, ptr_d;

  // NOTE: every variable gets its hold value first, so no path through the
  // block leaves it unassigned and no latch is inferred.
  always_comb begin
    digits_d = digits_q;
    ptr_d    = ptr_q;
    if (clear_i) begin
      digits_d = '0;
      ptr_d    = '0;
    end else if (inc_i) begin
      digits_d[ptr_q] = bcd_inc(digits_q[ptr_q]);
    end else if (next_i) begin
      ptr_d = (ptr_q == LAST_PTR) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  // NOTE: the digit storage is a register file that must read back as all
  // zeros after reset, so it is reset explicitly rather than left undefined.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      ptr_q    <= '0;
    end else begin
      digits_q <= digits_d;
      ptr_q    <= ptr_d;
    end
  end

  assign ptr_o    = ptr_q;
  assign digits_o = digits_q;

endmodule

// File: rtl/lock_controller.sv
// -----------------------------------------------------------------------------
// lock_controller
// Top-level sequencer for the combination lock: digit entry, code compare,
// open/relock timing, code re-programming and lockout after repeated failures.
//   clk               in   system clock
//   rst               in   synchronous active-high reset
//   btn_inc           in   pulse: increment digit under pointer
//   btn_next          in   pulse: advance pointer
//   btn_enter         in   pulse: submit entry / store code / relock
//   btn_set           in   pulse: start code programming (OPEN only)
//   state             out  current FSM state (lock_pkg::state_e encoding)
//   position_pointer  out  digit being edited
//   entry_digits      out  packed BCD entry
//   unlocked          out  high while OPEN
//   alarm             out  high while LOCKOUT
// All outputs come straight from flops; a button's effect shows the cycle
// after its pulse.
// -----------------------------------------------------------------------------
module lock_controller #(
  parameter int NUM_DIGITS     = lock_pkg::NUM_DIGITS,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int OPEN_CYCLES    = 500,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter logic [NUM_DIGITS*lock_pkg::DIGIT_W-1:0] DEFAULT_CODE = '0,
  localparam int PTR_W         = $clog2(NUM_DIGITS),
  localparam int CODE_W        = NUM_DIGITS * lock_pkg::DIGIT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_inc,
  input  logic              btn_next,
  input  logic              btn_enter,
  input  logic              btn_set,
  output logic [2:0]        state,
  output logic [PTR_W-1:0]  position_pointer,
  output logic [CODE_W-1:0] entry_digits,
  output logic              unlocked,
  output logic              alarm
);

  import lock_pkg::*;

  localparam int TIMER_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int ATT_W     = $clog2(MAX_ATTEMPTS + 1);

  // Timer is loaded with N-1 so that the state is held for exactly N cycles,
  // the last of which sees the timer at 0.
  localparam logic [TIMER_W-1:0] OPEN_LOAD    = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [ATT_W-1:0]   ATT_LIMIT    = ATT_W'(MAX_ATTEMPTS);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [ATT_W-1:0]    attempts_q, attempts_d;
  logic [ATT_W-1:0]    attempts_inc;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                unlocked_q, alarm_q;

  btn_e                btn;
  logic                bank_inc, bank_next, bank_clear;
  logic [PTR_W-1:0]    bank_ptr;
  logic [CODE_W-1:0]   bank_digits;

  assign btn          = pick_btn(btn_inc, btn_next, btn_enter, btn_set);
  assign attempts_inc = attempts_q + ATT_W'(1);

  digit_entry_bank #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_digits (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (bank_inc),
    .next_i   (bank_next),
    .clear_i  (bank_clear),
    .ptr_o    (bank_ptr),
    .digits_o (bank_digits)
  );

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    attempts_d = attempts_q;
    timer_d    = timer_q;
    bank_inc   = 1'b0;
    bank_next  = 1'b0;
    bank_clear = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The waking pulse only starts entry; it does not edit a digit.
        if (btn == BTN_INC || btn == BTN_NEXT || btn == BTN_ENTER) begin
          state_d = ST_ENTRY;
        end
      end

      ST_ENTRY, ST_SET_CODE: begin
        case (btn)
          BTN_ENTER: begin
            if (state_q == ST_ENTRY) begin
              state_d = ST_CHECK;
            end else begin
              code_d     = bank_digits;
              bank_clear = 1'b1;
              state_d    = ST_IDLE;
            end
          end
          BTN_NEXT: bank_next = 1'b1;
          BTN_INC:  bank_inc  = 1'b1;
          default:  ;
        endcase
      end

      ST_CHECK: begin
        bank_clear = 1'b1;
        if (bank_digits == code_q) begin
          attempts_d = '0;
          timer_d    = OPEN_LOAD;
          state_d    = ST_OPEN;
        end else if (attempts_inc == ATT_LIMIT) begin
          attempts_d = attempts_inc;
          timer_d    = LOCKOUT_LOAD;
          state_d    = ST_LOCKOUT;
        end else begin
          attempts_d = attempts_inc;
          state_d    = ST_ENTRY;
        end
      end

      ST_OPEN: begin
        if (btn == BTN_ENTER || timer_q == '0) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (btn == BTN_SET) begin
          bank_clear = 1'b1;
          timer_d    = '0;
          state_d    = ST_SET_CODE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          attempts_d = '0;
          state_d    = ST_IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      code_q     <= DEFAULT_CODE;
      attempts_q <= '0;
      timer_q    <= '0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      attempts_q <= attempts_d;
      timer_q    <= timer_d;
      // Decoded from the next state so the flags line up with the state output.
      unlocked_q <= (state_d == ST_OPEN);
      alarm_q    <= (state_d == ST_LOCKOUT);
    end
  end

  assign state            = state_q;
  assign position_pointer = bank_ptr;
  assign entry_digits     = bank_digits;
  assign unlocked         = unlocked_q;
  assign alarm            = alarm_q;

endmodule

// File: tb/tb_lock_controller.sv
// -----------------------------------------------------------------------------
// tb_lock_controller
// Scoreboard bench: each stimulus cycle pushes the outputs the lock must show
// after that edge; a monitor pops and compares them just after the edge.
// -----------------------------------------------------------------------------
module tb_lock_controller;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_OPEN    = 3'd3;
  localparam logic [2:0] S_SETCODE = 3'd4;
  localparam logic [2:0] S_LOCKOUT = 3'd5;

  // Button vector: {rst, set, enter, next, inc}
  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_INC   = 5'b00001;
  localparam logic [4:0] B_NEXT  = 5'b00010;
  localparam logic [4:0] B_ENTER = 5'b00100;
  localparam logic [4:0] B_SET   = 5'b01000;
  localparam logic [4:0] B_RST   = 5'b10000;

  localparam logic [31:0] NEW_CODE = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst, btn_inc, btn_next, btn_enter, btn_set;
  logic [2:0]  state;
  logic [2:0]  position_pointer;
  logic [31:0] entry_digits;
  logic        unlocked, alarm;

  always #5 clk = ~clk;

  lock_controller #(
    .NUM_DIGITS     (8),
    .MAX_ATTEMPTS   (3),
    .OPEN_CYCLES    (500),
    .LOCKOUT_CYCLES (1000),
    .DEFAULT_CODE   (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .btn_inc          (btn_inc),
    .btn_next         (btn_next),
    .btn_enter        (btn_enter),
    .btn_set          (btn_set),
    .state            (state),
    .position_pointer (position_pointer),
    .entry_digits     (entry_digits),
    .unlocked         (unlocked),
    .alarm            (alarm)
  );

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [2:0]  ptr;
    logic [31:0] entry;
    logic        unl;
    logic        alm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare just after each rising edge against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({e.tag, ".state"}, 32'(state), 32'(e.st));
        check({e.tag, ".ptr"},   32'(position_pointer), 32'(e.ptr));
        check({e.tag, ".entry"}, entry_digits, e.entry);
        check({e.tag, ".unlocked"}, 32'(unlocked), 32'(e.unl));
        check({e.tag, ".alarm"}, 32'(alarm), 32'(e.alm));
      end
    end
  end

  // Drive one cycle of buttons and queue the outputs expected after that edge.
  task automatic go(input string tag, input logic [4:0] b, input logic [2:0] st,
                    input logic [2:0] ptr, input logic [31:0] entry,
                    input logic unl, input logic alm);
    exp_t e;
    @(negedge clk);
    {rst, btn_set, btn_enter, btn_next, btn_inc} = b;
    e.tag = tag; e.st = st; e.ptr = ptr; e.entry = entry; e.unl = unl; e.alm = alm;
    sb.push_back(e);
    @(posedge clk);
    #2;
    {rst, btn_set, btn_enter, btn_next, btn_inc} = B_NONE;
  endtask

  // Key in a code digit by digit (digit0 first), leaving the pointer on digit 7.
  task automatic key_code(input logic [31:0] code, input logic [2:0] st);
    logic [31:0] e;
    logic [3:0]  val;
    e = '0;
    for (int d = 0; d < 8; d++) begin
      val = code[4*d +: 4];
      for (int k = 1; k <= int'(val); k++) begin
        e[4*d +: 4] = 4'(k);
        go("key_inc", B_INC, st, 3'(d), e, 1'b0, 1'b0);
      end
      if (d < 7) go("key_next", B_NEXT, st, 3'(d + 1), e, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [4:0] b;
    {rst, btn_set, btn_enter, btn_next, btn_inc} = B_RST;

    // Reset and basic editing
    go("reset", B_RST, S_IDLE, 3'd0, 32'h0, 1'b0, 1'b0);
    go("idle_wake", B_INC, S_ENTRY, 3'd0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++)
      go("inc_d0", B_INC, S_ENTRY, 3'd0, 32'(i), 1'b0, 1'b0);
    go("next", B_NEXT, S_ENTRY, 3'd1, 32'h3, 1'b0, 1'b0);
    go("inc_d1", B_INC, S_ENTRY, 3'd1, 32'h13, 1'b0, 1'b0);
    go("set_in_entry", B_SET, S_ENTRY, 3'd1, 32'h13, 1'b0, 1'b0);
    go("next_beats_inc", B_NEXT | B_INC, S_ENTRY, 3'd2, 32'h13, 1'b0, 1'b0);
    go("enter_wrong", B_ENTER, S_CHECK, 3'd2, 32'h13, 1'b0, 1'b0);
    go("check_fail", B_NONE, S_ENTRY, 3'd0, 32'h0, 1'b0, 1'b0);

    // Digit and pointer wrap
    for (int i = 1; i <= 10; i++)
      go("inc_wrap", B_INC, S_ENTRY, 3'd0, 32'(i % 10), 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++)
      go("next_wrap", B_NEXT, S_ENTRY, 3'(i % 8), 32'h0, 1'b0, 1'b0);

    // Default code opens; stays open exactly 500 cycles, then relocks
    go("enter_default", B_ENTER, S_CHECK, 3'd0, 32'h0, 1'b0, 1'b0);
    go("check_ignores_inc", B_INC, S_OPEN, 3'd0, 32'h0, 1'b1, 1'b0);
    for (int i = 1; i < 500; i++) begin
      b = (i == 5) ? B_INC : (i == 6) ? B_NEXT : B_NONE;
      go("open_hold", b, S_OPEN, 3'd0, 32'h0, 1'b1, 1'b0);
    end
    go("open_expire", B_NONE, S_IDLE, 3'd0, 32'h0, 1'b0, 1'b0);

    // Three wrong codes lock out for 1000 cycles (attempts were cleared by the open)
    go("wake2", B_INC, S_ENTRY, 3'd0, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      go("bad_inc", B_INC, S_ENTRY, 3'd0, 32'h1, 1'b0, 1'b0);
      go("bad_enter", B_ENTER, S_CHECK, 3'd0, 32'h1, 1'b0, 1'b0);
      if (k < 3) go("bad_fail", B_NONE, S_ENTRY, 3'd0, 32'h0, 1'b0, 1'b0);
      else       go("lockout", B_NONE, S_LOCKOUT, 3'd0, 32'h0, 1'b0, 1'b1);
    end
    for (int i = 1; i < 1000; i++) begin
      case (i % 4)
        0:       b = B_ENTER;
        1:       b = B_INC;
        2:       b = B_NEXT;
        default: b = B_SET;
      endcase
      go("lockout_hold", b, S_LOCKOUT, 3'd0, 32'h0, 1'b0, 1'b1);
    end
    go("lockout_end", B_NONE, S_IDLE, 3'd0, 32'h0, 1'b0, 1'b0);

    // Reprogram to 12345678 from OPEN
    go("wake3", B_INC, S_ENTRY, 3'd0, 32'h0, 1'b0, 1'b0);
    go("enter_open", B_ENTER, S_CHECK, 3'd0, 32'h0, 1'b0, 1'b0);
    go("opened", B_NONE, S_OPEN, 3'd0, 32'h0, 1'b1, 1'b0);
    go("set", B_SET, S_SETCODE, 3'd0, 32'h0, 1'b0, 1'b0);
    key_code(NEW_CODE, S_SETCODE);
    go("store", B_ENTER, S_IDLE, 3'd0, 32'h0, 1'b0, 1'b0);

    // Old code now fails, new code opens
    go("wake4", B_INC, S_ENTRY, 3'd0, 32'h0, 1'b0, 1'b0);
    go("old_code", B_ENTER, S_CHECK, 3'd0, 32'h0, 1'b0, 1'b0);
    go("old_fail", B_NONE, S_ENTRY, 3'd0, 32'h0, 1'b0, 1'b0);
    key_code(NEW_CODE, S_ENTRY);
    go("new_code", B_ENTER, S_CHECK, 3'd7, NEW_CODE, 1'b0, 1'b0);
    go("new_open", B_NONE, S_OPEN, 3'd0, 32'h0, 1'b1, 1'b0);
    go("open_enter", B_ENTER, S_IDLE, 3'd0, 32'h0, 1'b0, 1'b0);

    // inc+enter together: enter wins, digit untouched
    go("wake5", B_INC, S_ENTRY, 3'd0, 32'h0, 1'b0, 1'b0);
    go("inc1", B_INC, S_ENTRY, 3'd0, 32'h1, 1'b0, 1'b0);
    go("inc_enter", B_INC | B_ENTER, S_CHECK, 3'd0, 32'h1, 1'b0, 1'b0);
    go("inc_enter_fail", B_NONE, S_ENTRY, 3'd0, 32'h0, 1'b0, 1'b0);

    // Reset restores default code; reset in OPEN returns to IDLE next edge
    go("reset2", B_RST, S_IDLE, 3'd0, 32'h0, 1'b0, 1'b0);
    go("wake6", B_INC, S_ENTRY, 3'd0, 32'h0, 1'b0, 1'b0);
    go("default_again", B_ENTER, S_CHECK, 3'd0, 32'h0, 1'b0, 1'b0);
    go("open_again", B_NONE, S_OPEN, 3'd0, 32'h0, 1'b1, 1'b0);
    go("rst_in_open", B_RST, S_IDLE, 3'd0, 32'h0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
